imem_loader: RTL

//  Byte-stream program loader; the write side of the 16-bit core's instruction memory.

---
 rtl/imem_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader driving the instruction memory write port
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd5;
`endif
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  logic [2:0]        state;
  logic [7:0]        len_hi;
  logic [7:0]        data_hi;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] word_idx;
  logic [15:0]       len_full;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  always_comb begin
    busy = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: busy = 1'b1;
`endif
      default: busy = 1'b0;
    endcase
  end

  assign in_ready = busy;
  assign accept   = in_valid && in_ready;
  assign len_full = {len_hi, in_byte};
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  // The core is released only while a cleanly finished frame is held in DONE.
  assign cpu_hold = (state != S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_hi     <= '0;
      data_hi    <= '0;
      words_left <= '0;
      word_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_HI;
            word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= in_byte;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            words_left <= len_full;
            if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN)
              state <= S_ERR;
            else
              state <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            data_hi <= in_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= csum ^ in_byte;
`endif
            state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx;
            imem_wdata <= {data_hi, in_byte};
            word_idx   <= word_idx + ADDR_W'(1);
            words_left <= words_left - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= csum ^ in_byte;
`endif
            if (words_left == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
`endif
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept)
            state <= (csum == in_byte) ? S_DONE : S_ERR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
